// File: rtl/dcache_pkg.sv
// ============================================================================
// Module : dcache_pkg
// Brief  : Shared types, FUNCT3 codes and alignment helpers for the data cache.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BLOCK_BITS = 128;

  // Byte offset inside the word after forcing natural alignment for the size.
  function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: return lo;
      F3_H, F3_HU: return {lo[1], 1'b0};
      default:     return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return lo[0];
      default:     return |lo;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_lsu_align.sv
// ============================================================================
// Module : dcache_lsu_align
// Brief  : Byte-lane select/extension for loads and byte-merge for stores.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_lsu_align
  import dcache_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] line_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] wdata_sh;
  logic [3:0]  byte_en;

  assign off      = align_offset(funct3_i, addr_lo_i);
  assign shifted  = line_word_i >> {off, 3'b000};
  assign wdata_sh = wdata_i << {off, 3'b000};

  always_comb begin
    load_data_o = line_word_i;
    byte_en     = 4'b1111;
    case (funct3_i)
      F3_B: begin
        load_data_o = {{24{shifted[7]}}, shifted[7:0]};
        byte_en     = 4'b0001 << off;
      end
      F3_BU: begin
        load_data_o = {24'd0, shifted[7:0]};
        byte_en     = 4'b0001 << off;
      end
      F3_H: begin
        load_data_o = {{16{shifted[15]}}, shifted[15:0]};
        byte_en     = 4'b0011 << off;
      end
      F3_HU: begin
        load_data_o = {16'd0, shifted[15:0]};
        byte_en     = 4'b0011 << off;
      end
      default: begin
        load_data_o = line_word_i;
        byte_en     = 4'b1111;
      end
    endcase
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign store_word_o[8*b +: 8] = byte_en[b] ? wdata_sh[8*b +: 8] : line_word_i[8*b +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/data_cache_controller.sv
// ============================================================================
// Module : data_cache_controller
// Brief  : Direct-mapped write-back/write-allocate data cache, 16-byte blocks.
//          Optional DCACHE_MISALIGN_TRAP_EN adds MISALIGNED and suppresses such accesses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_cache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MEM_READ,
  input  logic                  MEM_WRITE,
  input  logic [31:0]           ADDRESS,
  input  logic [31:0]           WRITEDATA,
  input  logic [2:0]            FUNCT3,
  output logic [31:0]           READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ_OUT,
  output logic                  MEM_WRITE_OUT,
  output logic [27:0]           MEM_ADDRESS,
  output logic [BLOCK_BITS-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_BITS-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef DCACHE_MISALIGN_TRAP_EN
  ,
  output logic                  MISALIGNED
`endif
);

  localparam int IDX = $clog2(NUM_SETS);
  localparam int TAG = 28 - IDX;

  logic [NUM_SETS-1:0]   valid_q;
  logic [NUM_SETS-1:0]   dirty_q;
  logic [TAG-1:0]        tag_q  [NUM_SETS];
  logic [BLOCK_BITS-1:0] data_q [NUM_SETS];
  logic [BLOCK_BITS-1:0] refill_q;
  state_e                state_q;

  logic [IDX-1:0]        idx;
  logic [TAG-1:0]        tag;
  logic [1:0]            word;
  logic [BLOCK_BITS-1:0] line;
  logic [BLOCK_BITS-1:0] line_d;
  logic [31:0]           rd_word;
  logic [31:0]           load_data;
  logic [31:0]           store_word;
  logic                  hit;
  logic                  req_raw;
  logic                  req;
  logic                  load_hit;

  assign idx     = ADDRESS[3+IDX:4];
  assign tag     = ADDRESS[31:4+IDX];
  assign word    = ADDRESS[3:2];
  assign line    = data_q[idx];
  assign rd_word = line[{word, 5'b00000} +: 32];
  assign hit     = valid_q[idx] & (tag_q[idx] == tag);
  assign req_raw = MEM_READ | MEM_WRITE;

`ifdef DCACHE_MISALIGN_TRAP_EN
  logic misal;
  assign misal      = is_misaligned(FUNCT3, ADDRESS[1:0]);
  assign MISALIGNED = req_raw & misal;
  assign req        = req_raw & ~misal;
`else
  assign req        = req_raw;
`endif

  dcache_lsu_align u_align (
    .funct3_i     (FUNCT3),
    .addr_lo_i    (ADDRESS[1:0]),
    .line_word_i  (rd_word),
    .wdata_i      (WRITEDATA),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  for (genvar w = 0; w < 4; w++) begin : g_word
    assign line_d[32*w +: 32] = (word == 2'(w)) ? store_word : line[32*w +: 32];
  end

  // A store takes priority whenever MEM_WRITE is high, so it never drives READDATA.
  assign load_hit = (state_q == IDLE) & req & hit & ~MEM_WRITE;
  assign READDATA = load_hit ? load_data : 32'd0;
  assign BUSYWAIT = ~RESET & ((state_q != IDLE) | (req & ~hit));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      MEM_READ_OUT  <= 1'b0;
      MEM_WRITE_OUT <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (MEM_WRITE) begin
                data_q[idx]  <= line_d;
                dirty_q[idx] <= 1'b1;
              end
            end else if (valid_q[idx] & dirty_q[idx]) begin
              state_q       <= WRITEBACK;
              MEM_WRITE_OUT <= 1'b1;
              MEM_ADDRESS   <= {tag_q[idx], idx};
              MEM_WRITEDATA <= line;
            end else begin
              state_q      <= REFILL;
              MEM_READ_OUT <= 1'b1;
              MEM_ADDRESS  <= ADDRESS[31:4];
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state_q       <= REFILL;
            MEM_WRITE_OUT <= 1'b0;
            MEM_READ_OUT  <= 1'b1;
            MEM_ADDRESS   <= ADDRESS[31:4];
          end
        end
        REFILL: begin
          if (!MEM_BUSYWAIT) begin
            state_q      <= UPDATE;
            MEM_READ_OUT <= 1'b0;
            refill_q     <= MEM_READDATA;
          end
        end
        UPDATE: begin
          data_q[idx]  <= refill_q;
          tag_q[idx]   <= tag;
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_cache_controller.sv
// ============================================================================
// Module : tb_data_cache_controller
// Brief  : Self-checking bench for data_cache_controller with a latency memory model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_cache_controller;
  import dcache_pkg::*;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd, wr;
  logic [31:0]  addr, wdata;
  logic [2:0]   f3;
  logic [31:0]  rdata;
  logic         busy;
  logic         mem_rd, mem_wr;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_busy;
  logic         misaligned;

  logic [127:0] mem_blk [256];
  int           cnt = 0;
  int           overlap = 0;
  logic [31:0]  ev_q [$];
  logic [31:0]  exp_q [$];
  int           exp_cyc_q [$];
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  data_cache_controller #(.NUM_SETS(8)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .MEM_READ      (rd),
    .MEM_WRITE     (wr),
    .ADDRESS       (addr),
    .WRITEDATA     (wdata),
    .FUNCT3        (f3),
    .READDATA      (rdata),
    .BUSYWAIT      (busy),
    .MEM_READ_OUT  (mem_rd),
    .MEM_WRITE_OUT (mem_wr),
    .MEM_ADDRESS   (mem_addr),
    .MEM_WRITEDATA (mem_wdata),
    .MEM_READDATA  (mem_rdata),
    .MEM_BUSYWAIT  (mem_busy)
`ifdef DCACHE_MISALIGN_TRAP_EN
    ,
    .MISALIGNED    (misaligned)
`endif
  );

`ifndef DCACHE_MISALIGN_TRAP_EN
  assign misaligned = 1'b0;
`endif

  // Memory model: a request completes in its LAT-th cycle.
  assign mem_busy  = (mem_rd | mem_wr) && (cnt < LAT - 1);
  assign mem_rdata = mem_blk[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_rd && mem_wr) overlap++;
    if ((mem_rd | mem_wr) && !mem_busy) begin
      cnt <= 0;
      if (mem_wr) mem_blk[mem_addr[7:0]] <= mem_wdata;
      ev_q.push_back({3'b000, mem_wr, mem_addr});
    end else if (mem_rd | mem_wr) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after the posedge that commits the access.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] fn, input logic [31:0] exp_data, input int exp_cyc,
                        input string tag);
    int cyc;
    rd = r; wr = w; addr = a; wdata = d; f3 = fn;
    exp_q.push_back(exp_data);
    exp_cyc_q.push_back(exp_cyc);
    cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, "_done"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_data"}, rdata, exp_q.pop_front());
    check_eq({tag, "_cyc"}, cyc, exp_cyc_q.pop_front());
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic expect_ev(input string tag, input logic w, input logic [27:0] a);
    logic [31:0] o;
    o = (ev_q.size() > 0) ? ev_q.pop_front() : 32'hFFFF_FFFF;
    check_eq(tag, o, {3'b000, w, a});
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) mem_blk[i] = '0;
    mem_blk[1] = {32'h0, 32'h0, 32'h8001_7FFF, 32'hDEAD_BEEF};
    mem_blk[3] = {32'h0, 32'h0, 32'h0, 32'h3333_3333};
    mem_blk[9] = {32'h0, 32'h0, 32'h0, 32'h9090_9090};
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; f3 = F3_W;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check_eq("rst_mem_addr", {4'd0, mem_addr}, 32'd0);
    check_eq("rst_mem_wdata", {31'd0, |mem_wdata}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    // 1: cold load
    access(1, 0, 32'h10, 0, F3_W, 32'hDEAD_BEEF, 5, "t1_lw");
    expect_ev("t1_ev_rd", 1'b0, 28'h1);

    // 2: store byte then signed/unsigned byte loads, all hits
    access(0, 1, 32'h13, 32'h80, F3_B, 32'h0, 0, "t2_sb");
    access(1, 0, 32'h13, 0, F3_B,  32'hFFFF_FF80, 0, "t2_lb");
    access(1, 0, 32'h13, 0, F3_BU, 32'h0000_0080, 0, "t2_lbu");
    access(1, 0, 32'h10, 0, F3_W,  32'h80AD_BEEF, 0, "t2_lw");
    check_eq("t2_no_traffic", ev_q.size(), 32'd0);

    // 3: dirty victim replaced
    access(1, 0, 32'h90, 0, F3_W, 32'h9090_9090, 8, "t3_lw");
    expect_ev("t3_ev_wb", 1'b1, 28'h1);
    expect_ev("t3_ev_rd", 1'b0, 28'h9);
    check_eq("t3_wb_data", mem_blk[1][31:0], 32'h80AD_BEEF);

    // 4: halfword loads
    access(1, 0, 32'h16, 0, F3_H,  32'hFFFF_8001, 5, "t4_lh");
    expect_ev("t4_ev_rd", 1'b0, 28'h1);
    access(1, 0, 32'h16, 0, F3_HU, 32'h0000_8001, 0, "t4_lhu");

    // 5: reset during refill
    rd = 1'b1; wr = 1'b0; addr = 32'h30; f3 = F3_W;
    cyc = 0;
    @(negedge clk);
    while (mem_rd !== 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check_eq("t5_refill_seen", {31'd0, mem_rd}, 32'd1);
    rst = 1'b1; rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_no_traffic", ev_q.size(), 32'd0);
    @(posedge clk); #1;
    access(1, 0, 32'h30, 0, F3_W, 32'h3333_3333, 5, "t5_lw_rep");
    expect_ev("t5_ev_rd", 1'b0, 28'h3);
    access(1, 0, 32'h10, 0, F3_W, 32'h80AD_BEEF, 5, "t5_lw_inval");
    expect_ev("t5_ev_rd1", 1'b0, 28'h1);

    // 6: read and write together is a store
    access(1, 1, 32'h20, 32'h1234_5678, F3_W, 32'h0, 5, "t6_sw");
    expect_ev("t6_ev_rd", 1'b0, 28'h2);
    access(1, 0, 32'h20, 0, F3_W, 32'h1234_5678, 0, "t6_lw");

`ifdef DCACHE_MISALIGN_TRAP_EN
    rd = 1'b1; wr = 1'b0; addr = 32'h22; f3 = F3_W;
    @(negedge clk);
    check_eq("t6_mis_flag", {31'd0, misaligned}, 32'd1);
    check_eq("t6_mis_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_mis_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b1; addr = 32'h22; wdata = 32'hAAAA_AAAA; f3 = F3_W;
    @(negedge clk);
    check_eq("t6_mis_sw_flag", {31'd0, misaligned}, 32'd1);
    @(posedge clk); #1;
    wr = 1'b0;
    access(1, 0, 32'h20, 0, F3_W, 32'h1234_5678, 0, "t6_lw_after_mis");
    check_eq("t6_mis_no_traffic", ev_q.size(), 32'd0);
`else
    access(1, 0, 32'h22, 0, F3_W, 32'h1234_5678, 0, "t6_lw_trunc");
    access(1, 0, 32'h17, 0, F3_H, 32'hFFFF_8001, 0, "t6_lh_trunc");
    access(0, 1, 32'h23, 32'h0000_BEEF, F3_H, 32'h0, 0, "t6_sh_trunc");
    access(1, 0, 32'h20, 0, F3_W, 32'hBEEF_5678, 0, "t6_lw_after_sh");
    check_eq("t6_no_mis", {31'd0, misaligned}, 32'd0);
`endif

    check_eq("rd_wr_overlap", overlap, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
